// File: rtl/particle_deposit_weights.sv
// -----------------------------------------------------------------------------
// particle_deposit_weights
// Bilinear particle-to-grid weighting unit. One particle position per input
// handshake is decoded into the four surrounding cells of a periodic
// NUM_ROWS x NUM_COLS grid. Each cell gets an exact area weight with 2*PFRAC
// fractional bits. The four weights always sum to 2^(2*PFRAC).
//
// Two-stage pipeline:
//   S1 holds the decoded indices, fractions and complements.
//   S2 holds the addresses and weights and is the output register.
// SERIAL=0 emits all four corners in one beat. SERIAL=1 emits one corner per
// beat, in lane 0.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_y, in_x            fixed-point position (whole part = index, PFRAC frac)
//   out_valid/out_ready   output handshake
//   out_addr              four corner addresses, lane k at [k*ADDRW +: ADDRW]
//   out_weight            four corner weights, lane k at [k*WWIDTH +: WWIDTH]
//   out_corner            corner index of the beat (0 in parallel mode)
//   out_last              last beat of the particle
//   done_cnt              particles fully emitted (wrapping)
//   clear_cnt             synchronous clear of done_cnt; wins over an increment
// -----------------------------------------------------------------------------
module particle_deposit_weights #(
   parameter int NUM_ROWS = 64,
   parameter int NUM_COLS = 64,
   parameter int PFRAC    = 12,
   parameter int SERIAL   = 0,
   parameter int CNTWIDTH = 16,
   localparam int RB      = $clog2(NUM_ROWS),
   localparam int CB      = $clog2(NUM_COLS),
   localparam int ADDRW   = RB + CB,
   localparam int WWIDTH  = 2 * PFRAC + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [RB+PFRAC-1:0]   in_y,
   input  logic [CB+PFRAC-1:0]   in_x,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*ADDRW-1:0]    out_addr,
   output logic [4*WWIDTH-1:0]   out_weight,
   output logic [1:0]            out_corner,
   output logic                  out_last,
   output logic [CNTWIDTH-1:0]   done_cnt,
   input  logic                  clear_cnt
);
   localparam int PW = PFRAC + 1;
   // Fractions and complements are carried on PFRAC+1 bits, so that a
   // fraction of zero yields a full weight of ONE.
   localparam logic [PW-1:0] ONE = {1'b1, {PFRAC{1'b0}}};

   // The exact product never exceeds 2^(2*PFRAC). It therefore fits in WWIDTH bits.
   function automatic logic [WWIDTH-1:0] area_mul(input logic [PW-1:0] a, input logic [PW-1:0] b);
      return WWIDTH'(a) * WWIDTH'(b);
   endfunction

   logic              s1_valid_q;
   logic [RB-1:0]     r_q, r1_q, r1_d;
   logic [CB-1:0]     c_q, c1_q, c1_d;
   logic [PW-1:0]     fx_q, fy_q, fxc_q, fyc_q, fxc_d, fyc_d;
   logic              s2_valid_q;
   logic              s2_last_s, s2_release_s, s2_free_s, s1_advance_s, in_fire_s;
   logic [ADDRW-1:0]  p_addr_s [4];
   logic [WWIDTH-1:0] p_w_s [4];
   logic [CNTWIDTH-1:0] done_cnt_q, done_cnt_d;

   // S2 frees only when its final beat is taken. Stalls propagate back from there.
   assign s2_release_s = s2_valid_q && out_ready && s2_last_s;
   assign s2_free_s    = !s2_valid_q || s2_release_s;
   assign s1_advance_s = s1_valid_q && s2_free_s;
   assign in_ready     = !s1_valid_q || s1_advance_s;
   assign in_fire_s    = in_valid && in_ready;
   assign out_valid    = s2_valid_q;
   assign out_last     = s2_last_s;
   assign done_cnt     = done_cnt_q;

   // Wrapped neighbour indices and weight complements of the incoming position
   always_comb begin
      r1_d  = in_y[RB+PFRAC-1:PFRAC] + RB'(1'b1);
      c1_d  = in_x[CB+PFRAC-1:PFRAC] + CB'(1'b1);
      fxc_d = ONE - {1'b0, in_x[PFRAC-1:0]};
      fyc_d = ONE - {1'b0, in_y[PFRAC-1:0]};
   end

   // S1: decode register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         r_q   <= '0;
         r1_q  <= '0;
         c_q   <= '0;
         c1_q  <= '0;
         fx_q  <= '0;
         fy_q  <= '0;
         fxc_q <= '0;
         fyc_q <= '0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
         end
         if (in_fire_s) begin
            r_q   <= in_y[RB+PFRAC-1:PFRAC];
            r1_q  <= r1_d;
            c_q   <= in_x[CB+PFRAC-1:PFRAC];
            c1_q  <= c1_d;
            fx_q  <= {1'b0, in_x[PFRAC-1:0]};
            fy_q  <= {1'b0, in_y[PFRAC-1:0]};
            fxc_q <= fxc_d;
            fyc_q <= fyc_d;
         end
      end
   end

   // Corner addresses {row, col} and area weights computed from S1
   always_comb begin
      p_addr_s[0] = {r_q,  c_q};
      p_addr_s[1] = {r_q,  c1_q};
      p_addr_s[2] = {r1_q, c_q};
      p_addr_s[3] = {r1_q, c1_q};
      p_w_s[0]    = area_mul(fxc_q, fyc_q);
      p_w_s[1]    = area_mul(fx_q,  fyc_q);
      p_w_s[2]    = area_mul(fxc_q, fy_q);
      p_w_s[3]    = area_mul(fx_q,  fy_q);
   end

   // S2 occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
      end else if (s2_free_s) begin
         s2_valid_q <= s1_valid_q;
      end
   end

   // Next value of the completed-particle counter
   always_comb begin
      if (clear_cnt) begin
         done_cnt_d = '0;
      end else if (s2_release_s) begin
         done_cnt_d = done_cnt_q + CNTWIDTH'(1'b1);
      end else begin
         done_cnt_d = done_cnt_q;
      end
   end

   // Completed-particle counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_cnt_q <= '0;
      end else begin
         done_cnt_q <= done_cnt_d;
      end
   end

   generate
      if (SERIAL != 0) begin : g_serial
         logic [1:0]        corner_q;
         logic [ADDRW-1:0]  hold_addr_q [1:3];
         logic [WWIDTH-1:0] hold_w_q [1:3];
         logic [ADDRW-1:0]  lane_addr_q, next_addr_s;
         logic [WWIDTH-1:0] lane_w_q, next_w_s;
         logic              beat_fire_s;

         assign beat_fire_s = s2_valid_q && out_ready;

         // Corner that follows the one currently presented in lane 0
         always_comb begin
            case (corner_q)
               2'd0: begin
                  next_addr_s = hold_addr_q[1];
                  next_w_s    = hold_w_q[1];
               end
               2'd1: begin
                  next_addr_s = hold_addr_q[2];
                  next_w_s    = hold_w_q[2];
               end
               default: begin
                  next_addr_s = hold_addr_q[3];
                  next_w_s    = hold_w_q[3];
               end
            endcase
         end

         // Load a particle from S1, or step lane 0 through the held corners on each taken beat
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               corner_q    <= 2'd0;
               lane_addr_q <= '0;
               lane_w_q    <= '0;
               for (int k = 1; k < 4; k++) begin
                  hold_addr_q[k] <= '0;
                  hold_w_q[k]    <= '0;
               end
            end else if (s1_advance_s) begin
               corner_q    <= 2'd0;
               lane_addr_q <= p_addr_s[0];
               lane_w_q    <= p_w_s[0];
               for (int k = 1; k < 4; k++) begin
                  hold_addr_q[k] <= p_addr_s[k];
                  hold_w_q[k]    <= p_w_s[k];
               end
            end else if (beat_fire_s) begin
               if (s2_last_s) begin
                  corner_q <= 2'd0;
               end else begin
                  corner_q    <= corner_q + 2'd1;
                  lane_addr_q <= next_addr_s;
                  lane_w_q    <= next_w_s;
               end
            end
         end

         assign out_addr   = {{(3*ADDRW){1'b0}}, lane_addr_q};
         assign out_weight = {{(3*WWIDTH){1'b0}}, lane_w_q};
         assign out_corner = corner_q;
         assign s2_last_s  = (corner_q == 2'd3);
      end else begin : g_parallel
         logic [4*ADDRW-1:0]  addr_q;
         logic [4*WWIDTH-1:0] w_q;

         // S2 output register: all four corners in one beat
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               addr_q <= '0;
               w_q    <= '0;
            end else if (s1_advance_s) begin
               addr_q <= {p_addr_s[3], p_addr_s[2], p_addr_s[1], p_addr_s[0]};
               w_q    <= {p_w_s[3], p_w_s[2], p_w_s[1], p_w_s[0]};
            end
         end

         assign out_addr   = addr_q;
         assign out_weight = w_q;
         assign out_corner = 2'd0;
         assign s2_last_s  = 1'b1;
      end
   endgenerate

endmodule

// File: tb/tb_particle_deposit_weights.sv
`timescale 1ns/1ps
module tb_particle_deposit_weights;
   localparam int NR = 64, NC = 64, PF = 12, CW = 16;
   localparam int AW = 12, WW = 25, XW = 18, YW = 18;
   localparam int ONEV = 1 << PF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, in_valid, out_ready, clear_cnt, ser_sel;
   logic [YW-1:0] in_y;
   logic [XW-1:0] in_x;
   logic in_valid_p, in_valid_s, in_ready_p, in_ready_s;
   logic out_valid_p, out_valid_s, out_last_p, out_last_s;
   logic [4*AW-1:0] out_addr_p, out_addr_s;
   logic [4*WW-1:0] out_weight_p, out_weight_s;
   logic [1:0] out_corner_p, out_corner_s;
   logic [CW-1:0] done_cnt_p, done_cnt_s;

   assign in_valid_p = in_valid && !ser_sel;
   assign in_valid_s = in_valid && ser_sel;

   logic cur_in_ready, cur_out_valid, cur_last;
   logic [4*AW-1:0] cur_addr;
   logic [4*WW-1:0] cur_w;
   logic [1:0] cur_corner;
   logic [CW-1:0] cur_done;
   assign cur_in_ready  = ser_sel ? in_ready_s   : in_ready_p;
   assign cur_out_valid = ser_sel ? out_valid_s  : out_valid_p;
   assign cur_last      = ser_sel ? out_last_s   : out_last_p;
   assign cur_addr      = ser_sel ? out_addr_s   : out_addr_p;
   assign cur_w         = ser_sel ? out_weight_s : out_weight_p;
   assign cur_corner    = ser_sel ? out_corner_s : out_corner_p;
   assign cur_done      = ser_sel ? done_cnt_s   : done_cnt_p;

   particle_deposit_weights #(.NUM_ROWS(NR), .NUM_COLS(NC), .PFRAC(PF), .SERIAL(0), .CNTWIDTH(CW)) dut_p (
      .clk(clk), .rst(rst), .in_valid(in_valid_p), .in_ready(in_ready_p), .in_y(in_y), .in_x(in_x),
      .out_valid(out_valid_p), .out_ready(out_ready), .out_addr(out_addr_p), .out_weight(out_weight_p),
      .out_corner(out_corner_p), .out_last(out_last_p), .done_cnt(done_cnt_p), .clear_cnt(clear_cnt));

   particle_deposit_weights #(.NUM_ROWS(NR), .NUM_COLS(NC), .PFRAC(PF), .SERIAL(1), .CNTWIDTH(CW)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_y(in_y), .in_x(in_x),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_addr(out_addr_s), .out_weight(out_weight_s),
      .out_corner(out_corner_s), .out_last(out_last_s), .done_cnt(done_cnt_s), .clear_cnt(clear_cnt));

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct packed { logic [XW-1:0] x; logic [YW-1:0] y; } part_t;
   part_t q[$];
   int beat_idx = 0;
   int exp_done[2] = '{0, 0};

   typedef struct {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [AW-1:0] a [4];
      logic [WW-1:0] w [4];
   } vec_t;
   vec_t tv [5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference: corner k = (row + k/2, col + k%2) on a torus, weight = product of 1-D hat weights
   function automatic logic [AW-1:0] model_addr(input logic [XW-1:0] x, input logic [YW-1:0] y, input int k);
      int row, col;
      row = (int'(y) / ONEV + k / 2) % NR;
      col = (int'(x) / ONEV + k % 2) % NC;
      return AW'(row * NC + col);
   endfunction

   function automatic logic [WW-1:0] model_w(input logic [XW-1:0] x, input logic [YW-1:0] y, input int k);
      int fx, fy, wx, wy;
      fx = int'(x) % ONEV;
      fy = int'(y) % ONEV;
      wx = (k % 2 == 1) ? fx : ONEV - fx;
      wy = (k / 2 == 1) ? fy : ONEV - fy;
      return WW'(wx * wy);
   endfunction

   task automatic finish_edge();
      @(posedge clk); #1;
      clear_cnt = 1'b0;
      in_valid  = 1'b0;
      #1;
   endtask

   // rmode: 0 out_ready=1, 1 toggles 1010.., 2 random. stop_beats>=0 leaves after that many beats.
   // clear_at>=0 pulses clear_cnt with the last beat of that particle.
   task automatic run_stream(input bit ser, input int nparts, input int rmode,
                             input int stop_beats, input int clear_at, output int beats_o);
      int sent, done_parts, cyc, beats, n;
      bit acc_prev, hold_prev, head_last;
      logic [4*AW-1:0] sa;
      logic [4*WW-1:0] sw;
      logic [1:0] sc;
      part_t p;
      sent = 0; done_parts = 0; cyc = 0; beats = 0;
      acc_prev = 1'b0; hold_prev = 1'b0;
      sa = '0; sw = '0; sc = 2'd0;
      ser_sel = ser;
      while (done_parts < nparts) begin
         @(posedge clk); #1;
         clear_cnt = 1'b0;
         if (acc_prev) in_valid = 1'b0;
         acc_prev = 1'b0;
         if (!in_valid && sent < nparts) begin
            in_x = XW'($urandom_range(0, (1 << XW) - 1));
            in_y = YW'($urandom_range(0, (1 << YW) - 1));
            if ($urandom_range(0, 3) == 0) in_x[PF-1:0] = '0;
            if ($urandom_range(0, 3) == 0) in_y[PF-1:0] = '0;
            in_valid = 1'b1;
         end
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         n = q.size();
         head_last = ser ? (beat_idx == 3) : 1'b1;
         chk("in_ready", 128'(cur_in_ready), 128'((n < 2) || (out_ready && head_last)));
         chk("done_cnt", 128'(cur_done), 128'(exp_done[ser]));
         if (n == 0) chk("idle_valid", 128'(cur_out_valid), 128'(0));
         if (hold_prev) begin
            chk("stall_valid", 128'(cur_out_valid), 128'(1));
            chk("stall_addr", 128'(cur_addr), 128'(sa));
            chk("stall_weight", 128'(cur_w), 128'(sw));
            chk("stall_corner", 128'(cur_corner), 128'(sc));
         end
         hold_prev = cur_out_valid && !out_ready;
         sa = cur_addr; sw = cur_w; sc = cur_corner;
         if (cur_out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_beat", 128'(1), 128'(0));
            end else begin
               p = q[0];
               if (ser) begin
                  chk("ser_addr", 128'(cur_addr[AW-1:0]), 128'(model_addr(p.x, p.y, beat_idx)));
                  chk("ser_weight", 128'(cur_w[WW-1:0]), 128'(model_w(p.x, p.y, beat_idx)));
                  chk("ser_upper_zero", 128'({cur_addr[4*AW-1:AW], cur_w[4*WW-1:WW]}), 128'(0));
                  chk("ser_corner", 128'(cur_corner), 128'(beat_idx));
                  chk("ser_last", 128'(cur_last), 128'(beat_idx == 3));
               end else begin
                  for (int k = 0; k < 4; k++) begin
                     chk("par_addr", 128'(cur_addr[k*AW +: AW]), 128'(model_addr(p.x, p.y, k)));
                     chk("par_weight", 128'(cur_w[k*WW +: WW]), 128'(model_w(p.x, p.y, k)));
                  end
                  chk("par_corner", 128'(cur_corner), 128'(0));
                  chk("par_last", 128'(cur_last), 128'(1));
               end
               beats++;
               if (!ser || beat_idx == 3) begin
                  void'(q.pop_front());
                  beat_idx = 0;
                  if (clear_at == done_parts) begin
                     clear_cnt = 1'b1;
                     exp_done[ser] = 0;
                  end else begin
                     exp_done[ser] = (exp_done[ser] + 1) % (1 << CW);
                  end
                  done_parts++;
               end else begin
                  beat_idx++;
               end
            end
         end
         if (in_valid && cur_in_ready) begin
            q.push_back('{x: in_x, y: in_y});
            sent++;
            acc_prev = 1'b1;
         end
         cyc++;
         if (cyc >= 2000) begin
            chk("stream_timeout", 128'(1), 128'(0));
            break;
         end
         if (stop_beats >= 0 && beats == stop_beats) break;
      end
      beats_o = beats;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b;
      logic [127:0] wsum;
      tv[0] = '{x: 18'd22528,  y: 18'd40960,  a: '{12'd645, 12'd646, 12'd709, 12'd710},
                w: '{25'h800000, 25'h800000, 25'd0, 25'd0}};
      tv[1] = '{x: 18'd259072, y: 18'd261120, a: '{12'd4095, 12'd4032, 12'd63, 12'd0},
                w: '{25'd3145728, 25'd1048576, 25'd9437184, 25'd3145728}};
      tv[2] = '{x: 18'd0,      y: 18'd0,      a: '{12'd0, 12'd1, 12'd64, 12'd65},
                w: '{25'h1000000, 25'd0, 25'd0, 25'd0}};
      tv[3] = '{x: 18'd4095,   y: 18'd262143, a: '{12'd4032, 12'd4033, 12'd0, 12'd1},
                w: '{25'd1, 25'd4095, 25'd4095, 25'd16769025}};
      tv[4] = '{x: 18'd69932,  y: 18'd139168, a: '{12'd2129, 12'd2130, 12'd2193, 12'd2194},
                w: '{25'd364416, 25'd28800, 25'd15184000, 25'd1200000}};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_cnt = 1'b0; ser_sel = 1'b0;
      in_x = '0; in_y = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid_p", 128'(out_valid_p), 128'(0));
      chk("rst_valid_s", 128'(out_valid_s), 128'(0));
      chk("rst_addr_p", 128'(out_addr_p), 128'(0));
      chk("rst_weight_p", 128'(out_weight_p), 128'(0));
      chk("rst_addr_s", 128'(out_addr_s), 128'(0));
      chk("rst_done_p", 128'(done_cnt_p), 128'(0));
      chk("rst_done_s", 128'(done_cnt_s), 128'(0));
      chk("rst_corner_s", 128'(out_corner_s), 128'(0));
      rst = 1'b0;
      #1;
      chk("rst_in_ready_p", 128'(in_ready_p), 128'(1));
      chk("rst_in_ready_s", 128'(in_ready_s), 128'(1));

      // Directed vectors on the parallel unit, one at a time, with latency checks
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         ser_sel = 1'b0; in_x = tv[i].x; in_y = tv[i].y; in_valid = 1'b1; out_ready = 1'b1;
         #1;
         chk("vec_in_ready", 128'(in_ready_p), 128'(1));
         @(posedge clk); #1;
         in_valid = 1'b0;
         #1;
         chk("vec_lat1_valid", 128'(out_valid_p), 128'(0));
         @(posedge clk); #2;
         chk("vec_lat2_valid", 128'(out_valid_p), 128'(1));
         wsum = '0;
         for (int k = 0; k < 4; k++) begin
            chk("vec_addr", 128'(out_addr_p[k*AW +: AW]), 128'(tv[i].a[k]));
            chk("vec_weight", 128'(out_weight_p[k*WW +: WW]), 128'(tv[i].w[k]));
            wsum = wsum + 128'(out_weight_p[k*WW +: WW]);
         end
         chk("vec_weight_sum", wsum, 128'(1 << (2 * PF)));
         chk("vec_last", 128'(out_last_p), 128'(1));
         chk("vec_corner", 128'(out_corner_p), 128'(0));
         exp_done[0]++;
         @(posedge clk); #2;
         chk("vec_drained", 128'(out_valid_p), 128'(0));
         chk("vec_done", 128'(done_cnt_p), 128'(i + 1));
      end

      // Parallel streams: 1010 back-pressure, random back-pressure, full rate
      run_stream(1'b0, 8, 1, -1, -1, b);
      chk("bp_beats", 128'(b), 128'(8));
      run_stream(1'b0, 24, 2, -1, -1, b);
      chk("rand_beats", 128'(b), 128'(24));
      run_stream(1'b0, 16, 0, -1, -1, b);
      chk("full_beats", 128'(b), 128'(16));
      finish_edge();
      chk("par_done_total", 128'(done_cnt_p), 128'(53));
      chk("par_queue_empty", 128'(q.size()), 128'(0));

      // Serial: three back-to-back particles give twelve beats
      run_stream(1'b1, 3, 0, -1, -1, b);
      chk("ser_beats", 128'(b), 128'(12));
      finish_edge();
      chk("ser_done3", 128'(done_cnt_s), 128'(3));
      run_stream(1'b1, 6, 2, -1, -1, b);
      chk("ser_rand_beats", 128'(b), 128'(24));
      finish_edge();

      // Reset while the serial unit presents corner 2
      run_stream(1'b1, 1, 0, 2, -1, b);
      @(posedge clk); #2;
      chk("pre_rst_corner", 128'(out_corner_s), 128'(2));
      chk("pre_rst_valid", 128'(out_valid_s), 128'(1));
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 128'(out_valid_s), 128'(0));
      chk("mid_rst_done_s", 128'(done_cnt_s), 128'(0));
      chk("mid_rst_done_p", 128'(done_cnt_p), 128'(0));
      chk("mid_rst_corner", 128'(out_corner_s), 128'(0));
      q.delete();
      beat_idx = 0;
      exp_done[0] = 0;
      exp_done[1] = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_stream(1'b1, 1, 0, -1, -1, b);
      chk("post_rst_beats", 128'(b), 128'(4));
      finish_edge();
      chk("post_rst_done", 128'(done_cnt_s), 128'(1));

      // Clear colliding with an out_last acceptance at done_cnt = 5
      run_stream(1'b0, 5, 0, -1, -1, b);
      finish_edge();
      chk("pre_clear_done", 128'(done_cnt_p), 128'(5));
      run_stream(1'b0, 1, 0, -1, 0, b);
      finish_edge();
      chk("clear_wins", 128'(done_cnt_p), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/particle_deposit_weights.md
Name: particle_deposit_weights

Overview:
- Parametrised bilinear particle-to-grid weighting unit for the charge-deposition path.
- Takes one particle position per handshake on a periodic NUM_ROWS x NUM_COLS grid and produces four corner cell addresses with exact area weights.
- Two output modes:
  - PARALLEL: all four corners in one beat.
  - SERIAL: one corner per beat, for single-port grid accumulators.
- Sits between the particle store and the charge-grid accumulator.

Parameters:
- NUM_ROWS, 64, grid rows; power of two, at least 2.
- NUM_COLS, 64, grid columns; power of two, at least 2.
- PFRAC, 12, fractional bits of each position coordinate.
- SERIAL, 0, 0 = four corners per beat, 1 = one corner per beat.
- CNTWIDTH, 16, width of the completed-particle counter.
- Derived: RB = $clog2(NUM_ROWS), CB = $clog2(NUM_COLS), ADDRW = RB+CB, WWIDTH = 2*PFRAC+1.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, particle position valid.
- in_ready, out, 1, block accepts the position this cycle.
- in_y, in, RB+PFRAC, y position: whole part is the row index, low PFRAC bits are the fraction.
- in_x, in, CB+PFRAC, x position: whole part is the column index, low PFRAC bits are the fraction.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts the beat.
- out_addr, out, 4*ADDRW, corner addresses; lane k at bits [k*ADDRW +: ADDRW].
- out_weight, out, 4*WWIDTH, corner weights, unsigned, 2*PFRAC fractional bits; lane k as for out_addr.
- out_corner, out, 2, corner index of the beat (SERIAL); tied 0 in PARALLEL.
- out_last, out, 1, last beat of the particle (always 1 in PARALLEL).
- done_cnt, out, CNTWIDTH, count of particles fully emitted.
- clear_cnt, in, 1, synchronous clear of done_cnt.

Behaviour:
- Reset: asynchronous, active-high. All stage valids, out_valid, the corner counter and done_cnt go to 0. out_addr and out_weight go to 0. in_ready is 1 after reset release. Reset mid-operation drops in-flight particles silently.
- Decode: r = in_y[RB+PFRAC-1:PFRAC], c = in_x[CB+PFRAC-1:PFRAC], fy and fx are the low PFRAC bits.
- Neighbours wrap periodically: r1 = (r+1) mod NUM_ROWS, c1 = (c+1) mod NUM_COLS. Wrap is implicit truncation.
- Address = row*NUM_COLS + col, formed as the concatenation {row, col}.
- Corner order and weights, with ONE = 2^PFRAC (PFRAC+1-bit complements, so a fraction of 0 gives a weight of exactly ONE, never truncated):
  - Corner 0: (r, c), weight (ONE-fx)*(ONE-fy).
  - Corner 1: (r, c1), weight fx*(ONE-fy).
  - Corner 2: (r1, c), weight (ONE-fx)*fy.
  - Corner 3: (r1, c1), weight fx*fy.
  - The four weights always sum to exactly 2^(2*PFRAC).
- Pipeline has two stages:
  - S1 registers r, c, r1, c1, fx, fy and the complements.
  - S2 registers the products and addresses; S2 is the output register.
  - Latency is 2 cycles from an accepted input to out_valid, with no stall.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - A stage advances when the next stage is empty or is releasing this cycle.
  - in_ready = !s1_valid || s1_advance, so full throughput is possible with back-pressure, and there are no combinational paths from out_ready to out_valid.
  - Outputs hold stable while out_valid && !out_ready.
- PARALLEL mode:
  - One beat per particle, out_last = 1, out_corner = 0.
  - Throughput is 1 particle per cycle.
- SERIAL mode:
  - The S2 register holds the particle while a 2-bit corner counter steps 0, 1, 2, 3 on each accepted beat.
  - Lane 0 of out_addr/out_weight carries the selected corner; lanes 1-3 are driven 0.
  - out_last = 1 when the counter is 3.
  - S2 frees only on acceptance of corner 3; the counter then returns to 0.
  - Throughput is 1 particle per 4 cycles; in_ready deasserts accordingly.
- done_cnt:
  - Increments on acceptance of each out_last beat and wraps at 2^CNTWIDTH.
  - If clear_cnt and an increment occur in the same cycle, the result is 0 (clear wins).
- in_valid must stay high with stable data until accepted. Behaviour when a protocol violation drops in_valid early is not guaranteed.

Test Plan:
- Interior point, PARALLEL: x = 5 + 0x800/4096, y = 10 + 0 -> after 2 cycles, addr = {645, 646, 709, 710}, weight = {0x800000, 0x800000, 0, 0}, out_last = 1, done_cnt = 1.
- Wrap corner: x = 63 + 0x400, y = 63 + 0xC00 -> addr = {4095, 4032, 63, 0}, weight = {3145728, 1048576, 9437184, 3145728}, sum = 16777216.
- Exact grid point: x = 0, y = 0 -> weight0 = 0x1000000 (full 25-bit one), other weights 0; verify no truncation.
- Back-pressure: stream 8 random particles with out_ready toggling 1010... -> no loss or duplication, outputs stable while stalled, in_ready low whenever both stages are full; compare against a reference model.
- SERIAL mode, 3 back-to-back particles -> 12 beats with out_corner cycling 0-3, out_last on every 4th beat, in_ready duty 1/4, done_cnt = 3; assert rst mid-particle at corner 2 -> out_valid = 0 immediately, done_cnt = 0, next particle starts at corner 0.
- Counter clear: assert clear_cnt in the same cycle as an out_last acceptance with done_cnt = 5 -> done_cnt = 0 next cycle.
